dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 51 +++++
 rtl/dmem_load_align.sv | 33 +++
 rtl/dmem_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte-lane data memory controller.
// Lanes are big-endian: byte offset 0 lives in lane 3 (bits 31:24).
package dmem_pkg;

   localparam int TIMEOUT_DEF = 8;
   localparam int NUM_LANES   = 4;
   localparam int LANE_MSB    = 3;
   localparam int LANE_LSB    = 0;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_e;

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b1000 >> off;
         SZ_HALF: m = off[1] ? 4'b0011 : 4'b1100;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic acc_err(input logic [1:0] size, input logic [31:0] addr);
      return (size == SZ_ILL)
          || (size == SZ_HALF && addr[0])
          || (size == SZ_WORD && addr[1:0] != 2'b00)
          || (addr[31:11] != 21'd0);
   endfunction

   // Narrow stores are replicated so every lane sees its byte in place.
   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] d;
      case (size)
         SZ_BYTE: d = {4{wdata[7:0]}};
         SZ_HALF: d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half out of the four big-endian lanes and
// sign- or zero-extends it to 32 bits.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        uns,
   input  logic [31:0] lanes,
   output logic [31:0] result
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = 8'd0;
      unique case (offset)
         2'd0: b = lanes[31:24];
         2'd1: b = lanes[23:16];
         2'd2: b = lanes[15:8];
         2'd3: b = lanes[7:0];
      endcase
      h = offset[1] ? lanes[15:0] : lanes[31:16];
      case (size)
         SZ_BYTE: result = {{24{~uns & b[7]}}, b};
         SZ_HALF: result = {{16{~uns & h[15]}}, h};
         SZ_WORD: result = lanes;
         default: result = 32'd0;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory controller: one access at a time over four
// byte-wide lanes, with per-lane valid collection and a WAIT timeout.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [3:0]  lane_rd_en,
   output logic [3:0]  lane_wr_en,
   output logic [8:0]  lane_addr,
   output logic [31:0] lane_wdata,
   input  logic [31:0] lane_rdata,
   input  logic [3:0]  lane_valid
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [10:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  mask_q, mask_d;
   logic        err_q, err_d;
   logic [3:0]  sticky_q, sticky_d;
   logic [31:0] ldata_q, ldata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic [31:0] merged;
   logic [31:0] aligned;
   logic        issue_ok;

   // Lanes whose valid arrives this cycle contribute live data.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++)
         merged[8*i +: 8] = lane_valid[i] ? lane_rdata[8*i +: 8] : ldata_q[8*i +: 8];
   end

   dmem_load_align u_align (
      .size   (size_q),
      .offset (addr_q[1:0]),
      .uns    (uns_q),
      .lanes  (merged),
      .result (aligned)
   );

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mask_d       = mask_q;
      err_d        = err_q;
      sticky_d     = sticky_q;
      ldata_d      = ldata_q;
      cnt_d        = cnt_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = 32'd0;
      resp_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: if (req_valid) begin
            state_d = ST_ISSUE;
            we_d    = req_we;
            size_d  = req_size;
            uns_d   = req_unsigned;
            addr_d  = req_addr[10:0];
            wdata_d = store_data(req_size, req_wdata);
            mask_d  = lane_mask(req_size, req_addr[1:0]);
            err_d   = acc_err(req_size, req_addr);
         end
         ST_ISSUE: begin
            sticky_d = 4'd0;
            ldata_d  = 32'd0;
            cnt_d    = '0;
            if (err_q) begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            sticky_d = sticky_q | (lane_valid & mask_q);
            ldata_d  = merged;
            cnt_d    = cnt_q + 1'b1;
            if ((sticky_d & mask_q) == mask_q) begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = we_q ? 32'd0 : aligned;
            end else if (cnt_d == CW'(TIMEOUT)) begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         size_q       <= SZ_BYTE;
         uns_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mask_q       <= '0;
         err_q        <= 1'b0;
         sticky_q     <= '0;
         ldata_q      <= '0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mask_q       <= mask_d;
         err_q        <= err_d;
         sticky_q     <= sticky_d;
         ldata_q      <= ldata_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Lane strobes exist only for the single ISSUE cycle of a legal access.
   assign issue_ok   = (state_q == ST_ISSUE) && !err_q;
   assign lane_rd_en = (issue_ok && !we_q) ? mask_q : 4'd0;
   assign lane_wr_en = (issue_ok &&  we_q) ? mask_q : 4'd0;
   assign lane_addr  = issue_ok ? addr_q[10:2] : 9'd0;
   assign lane_wdata = (issue_ok && we_q) ? wdata_q : 32'd0;

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule
